// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: formats EX/MEM accesses onto a valid/ready data bus,
// extends load data, and flags misaligned accesses, bus errors and timeouts.
module mem_stage_lsu #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr_en_in,
  input  logic [2:0]  lsu_ctrl_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] ld_data,
  output logic        misalign_fault,
  output logic        bus_fault,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_be,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  input  logic        dmem_rsp_err
);

  localparam logic [2:0] LSU_NOP = 3'd0;
  localparam logic [2:0] LSU_B   = 3'd1;
  localparam logic [2:0] LSU_H   = 3'd2;
  localparam logic [2:0] LSU_W   = 3'd3;
  localparam logic [2:0] LSU_BU  = 3'd4;
  localparam logic [2:0] LSU_HU  = 3'd5;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] TMO_LAST = (BUS_TIMEOUT > 0) ? 32'(BUS_TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] wcnt;
  logic [31:0] ld_q;
  logic        mis_q;
  logic        bus_q;

  logic        start;
  logic [1:0]  size;
  logic        uns;
  logic        misaligned;
  logic        timeout;

  function automatic logic [31:0] fmt_wdata(input logic [1:0] sz, input logic [31:0] rs2);
    case (sz)
      SZ_B:    fmt_wdata = {4{rs2[7:0]}};
      SZ_H:    fmt_wdata = {2{rs2[15:0]}};
      default: fmt_wdata = rs2;
    endcase
  endfunction

  function automatic logic [3:0] fmt_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    fmt_be = 4'b0001 << off;
      SZ_H:    fmt_be = 4'b0011 << off;
      default: fmt_be = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] sz,
                                              input logic unsgn, input logic [1:0] off);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic signed [31:0] sx;
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = rdata[{off[1], 4'b0000} +: 16];
    case (sz)
      SZ_B: begin
        sx = lane_b;
        extend_load = unsgn ? {24'd0, lane_b} : sx;
      end
      SZ_H: begin
        sx = lane_h;
        extend_load = unsgn ? {16'd0, lane_h} : sx;
      end
      default: extend_load = rdata;
    endcase
  endfunction

  // Decode of the incoming EX/MEM access; unsigned variants only matter for loads.
  always_comb begin
    size = SZ_W;
    uns  = 1'b0;
    case (lsu_ctrl_in)
      LSU_B:   size = SZ_B;
      LSU_H:   size = SZ_H;
      LSU_W:   size = SZ_W;
      LSU_BU:  begin size = SZ_B; uns = ~mem_wr_en_in; end
      LSU_HU:  begin size = SZ_H; uns = ~mem_wr_en_in; end
      default: size = SZ_W;
    endcase
    start      = (state == S_IDLE) && (lsu_ctrl_in != LSU_NOP);
    misaligned = ((size == SZ_H) && alu_result_in[0]) ||
                 ((size == SZ_W) && (alu_result_in[1:0] != 2'b00));
    timeout    = (BUS_TIMEOUT != 0) && (wcnt == TMO_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wcnt    <= 32'd0;
      ld_q    <= 32'd0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mis_q <= misaligned;
            bus_q <= 1'b0;
            ld_q  <= 32'd0;
            if (misaligned) begin
              state <= S_DONE;
            end else begin
              we_q    <= mem_wr_en_in;
              size_q  <= size;
              uns_q   <= uns;
              off_q   <= alu_result_in[1:0];
              addr_q  <= {alu_result_in[31:2], 2'b00};
              wdata_q <= fmt_wdata(size, rs2_data_in);
              be_q    <= fmt_be(size, alu_result_in[1:0]);
              state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            wcnt  <= 32'd0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the same cycle as the timeout still wins.
          if (dmem_rsp_valid) begin
            bus_q <= dmem_rsp_err;
            ld_q  <= (dmem_rsp_err || we_q) ? 32'd0
                                            : extend_load(dmem_rsp_rdata, size_q, uns_q, off_q);
            state <= S_DONE;
          end else if (timeout) begin
            bus_q <= 1'b1;
            ld_q  <= 32'd0;
            state <= S_DONE;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu_stall      = start || (state == S_REQ) || (state == S_WAIT);
  assign lsu_done       = (state == S_DONE);
  assign ld_data        = ld_q;
  assign misalign_fault = (state == S_DONE) && mis_q;
  assign bus_fault      = (state == S_DONE) && bus_q;
  assign dmem_req_valid = (state == S_REQ);
  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_be    = be_q;

endmodule
